// File: rtl/apb_arb_pkg.sv
// Shared constants for the two-requester APB arbiter.
//   State encoding for the arbiter FSM, grant ids, and the READ_WRITE
//   levels the APB master bridge expects (1 = read).
package apb_arb_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Requester write flag (1 = write) to bridge READ_WRITE level.
    function automatic logic rw_from_wr(input logic wr);
        return wr ? RW_WRITE : RW_READ;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
//   req_a, req_b   : pending requests
//   last_grant     : id of the previous winner (GNT_A / GNT_B)
//   gnt_valid_c    : at least one request pending
//   gnt_id_c       : winner id; on a tie the requester that did not win last
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_valid_c,
    output logic gnt_id_c
);

    always_comb begin
        gnt_valid_c = req_a | req_b;
        gnt_id_c    = GNT_A;
        if (req_a && req_b) begin
            gnt_id_c = (last_grant == GNT_A) ? GNT_B : GNT_A;
        end else if (req_b) begin
            gnt_id_c = GNT_B;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master bridge between requesters A and B.
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   req/wr/addr/wdata_a|b  : requester commands (req held until ack)
//   ack/rdata/err_a|b      : one-cycle completion pulse with read data / error
//   transfer, READ_WRITE,
//   apb_write_paddr, apb_read_paddr, apb_write_data : bridge command inputs
//   PSEL_any, PENABLE, PREADY, PRDATA, PSLVERR      : bus taps for completion
// FSM IDLE -> GRANT -> WAIT -> RESP -> IDLE; every output comes from a flop.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,

    input  logic                 req_a,
    input  logic                 wr_a,
    input  logic [ADDRWIDTH:0]   addr_a,
    input  logic [DATAWIDTH-1:0] wdata_a,
    output logic                 ack_a,
    output logic [DATAWIDTH-1:0] rdata_a,
    output logic                 err_a,

    input  logic                 req_b,
    input  logic                 wr_b,
    input  logic [ADDRWIDTH:0]   addr_b,
    input  logic [DATAWIDTH-1:0] wdata_b,
    output logic                 ack_b,
    output logic [DATAWIDTH-1:0] rdata_b,
    output logic                 err_b,

    output logic                 transfer,
    output logic                 READ_WRITE,
    output logic [ADDRWIDTH:0]   apb_write_paddr,
    output logic [ADDRWIDTH:0]   apb_read_paddr,
    output logic [DATAWIDTH-1:0] apb_write_data,

    input  logic                 PSEL_any,
    input  logic                 PENABLE,
    input  logic                 PREADY,
    input  logic [DATAWIDTH-1:0] PRDATA,
    input  logic                 PSLVERR
);

    // Watchdog sizing; a disabled watchdog still keeps a 1-bit timer.
    localparam int unsigned  TW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic         TO_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TSAT = {TW{1'b1}};

    logic [ST_W-1:0]      state_q,      state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 winner_q,     winner_d;
    logic                 cmd_wr_q,     cmd_wr_d;
    logic [ADDRWIDTH:0]   paddr_q,      paddr_d;
    logic [DATAWIDTH-1:0] wdata_q,      wdata_d;
    logic                 transfer_q,   transfer_d;
    logic                 read_write_q, read_write_d;
    logic [TW-1:0]        timer_q,      timer_d;
    logic                 ack_a_q,      ack_a_d;
    logic                 ack_b_q,      ack_b_d;
    logic [DATAWIDTH-1:0] rdata_a_q,    rdata_a_d;
    logic [DATAWIDTH-1:0] rdata_b_q,    rdata_b_d;
    logic                 err_a_q,      err_a_d;
    logic                 err_b_q,      err_b_d;

    logic                 gnt_valid_c;
    logic                 gnt_id_c;
    logic                 done_c;
    logic                 resp_fire_c;
    logic [DATAWIDTH-1:0] resp_rdata_c;
    logic                 resp_err_c;

    rr_arb2 u_rr_arb2 (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_id_c    (gnt_id_c)
    );

    // Bus-side completion of the current access phase.
    assign done_c = PSEL_any & PENABLE & PREADY;

    // Next-state, command latch, watchdog and response capture.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        cmd_wr_d     = cmd_wr_q;
        paddr_d      = paddr_q;
        wdata_d      = wdata_q;
        transfer_d   = transfer_q;
        read_write_d = read_write_q;
        timer_d      = timer_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        err_a_d      = err_a_q;
        err_b_d      = err_b_q;
        resp_fire_c  = 1'b0;
        resp_rdata_c = '0;
        resp_err_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_c) begin
                    // Latch the winner's command; it drives the bridge during GRANT.
                    winner_d     = gnt_id_c;
                    last_grant_d = gnt_id_c;
                    cmd_wr_d     = (gnt_id_c == GNT_B) ? wr_b    : wr_a;
                    paddr_d      = (gnt_id_c == GNT_B) ? addr_b  : addr_a;
                    wdata_d      = (gnt_id_c == GNT_B) ? wdata_b : wdata_a;
                    read_write_d = rw_from_wr((gnt_id_c == GNT_B) ? wr_b : wr_a);
                    transfer_d   = 1'b1;
                    state_d      = ST_GRANT;
                end
            end

            ST_GRANT: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (done_c) begin
                    // Completion takes priority over a coincident timeout.
                    transfer_d   = 1'b0;
                    resp_fire_c  = 1'b1;
                    resp_rdata_c = cmd_wr_q ? '0 : PRDATA;
                    resp_err_c   = PSLVERR;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = (timer_q == TSAT) ? timer_q : timer_q + TW'(1);
                    if (TO_EN && (timer_q == TMAX)) begin
                        transfer_d   = 1'b0;
                        resp_fire_c  = 1'b1;
                        resp_rdata_c = '0;
                        resp_err_c   = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Route the response to the owner only; the other side holds its outputs.
        if (resp_fire_c) begin
            if (winner_q == GNT_B) begin
                ack_b_d   = 1'b1;
                rdata_b_d = resp_rdata_c;
                err_b_d   = resp_err_c;
            end else begin
                ack_a_d   = 1'b1;
                rdata_a_d = resp_rdata_c;
                err_a_d   = resp_err_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_B;
            winner_q     <= GNT_A;
            cmd_wr_q     <= 1'b0;
            paddr_q      <= '0;
            wdata_q      <= '0;
            transfer_q   <= 1'b0;
            read_write_q <= 1'b0;
            timer_q      <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            cmd_wr_q     <= cmd_wr_d;
            paddr_q      <= paddr_d;
            wdata_q      <= wdata_d;
            transfer_q   <= transfer_d;
            read_write_q <= read_write_d;
            timer_q      <= timer_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            err_a_q      <= err_a_d;
            err_b_q      <= err_b_d;
        end
    end

    assign ack_a           = ack_a_q;
    assign ack_b           = ack_b_q;
    assign rdata_a         = rdata_a_q;
    assign rdata_b         = rdata_b_q;
    assign err_a           = err_a_q;
    assign err_b           = err_b_q;
    assign transfer        = transfer_q;
    assign READ_WRITE      = read_write_q;
    assign apb_write_paddr = paddr_q;
    assign apb_read_paddr  = paddr_q;
    assign apb_write_data  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: a small APB bridge + two-slave model, directed
// requester stimulus, and a scoreboard monitor that checks every ack.
module tb_apb_req_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_a, wr_a, req_b, wr_b;
    logic [AW:0]   addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic          ack_a, ack_b, err_a, err_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          transfer, READ_WRITE;
    logic [AW:0]   apb_write_paddr, apb_read_paddr;
    logic [DW-1:0] apb_write_data;
    logic          PSEL_any, PENABLE, PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;

    apb_req_arbiter #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_a(req_a), .wr_a(wr_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a), .err_a(err_a),
        .req_b(req_b), .wr_b(wr_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b), .err_b(err_b),
        .transfer(transfer), .READ_WRITE(READ_WRITE),
        .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
        .apb_write_data(apb_write_data),
        .PSEL_any(PSEL_any), .PENABLE(PENABLE), .PREADY(PREADY),
        .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Bridge + slave model: mem1 at addr[8]=0, mem2 at addr[8]=1.
    // Memories reload on reset: mem1[i] = i^0x55, mem2[i] = i^0xAA.
    logic [1:0]    br_st;
    logic [DW-1:0] mem1 [256];
    logic [DW-1:0] mem2 [256];
    logic          pready_en;
    logic          slverr_en;

    assign PSEL_any = (br_st != 2'd0);
    assign PENABLE  = (br_st == 2'd2);
    assign PREADY   = pready_en;
    assign PRDATA   = apb_read_paddr[AW] ? mem2[apb_read_paddr[AW-1:0]]
                                         : mem1[apb_read_paddr[AW-1:0]];
    assign PSLVERR  = slverr_en & PSEL_any & PENABLE & PREADY;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            br_st <= 2'd0;
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= 8'(i) ^ 8'h55;
                mem2[i] <= 8'(i) ^ 8'hAA;
            end
        end else begin
            case (br_st)
                2'd0: if (transfer) br_st <= 2'd1;
                2'd1: br_st <= 2'd2;
                default: begin
                    if (PREADY) begin
                        if (!READ_WRITE) begin
                            if (apb_write_paddr[AW]) mem2[apb_write_paddr[AW-1:0]] <= apb_write_data;
                            else                     mem1[apb_write_paddr[AW-1:0]] <= apb_write_data;
                        end
                        br_st <= 2'd0;
                    end else if (!transfer) begin
                        br_st <= 2'd0;
                    end
                end
            endcase
        end
    end

    // Scoreboard.
    typedef struct packed {
        logic          side;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfer_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge PCLK) if (transfer) xfer_cnt++;

    // Monitor: pops one expectation per ack; the idle side must hold its outputs.
    logic [DW-1:0] hold_rd_a = '0, hold_rd_b = '0;
    logic          hold_err_a = 1'b0, hold_err_b = 1'b0;
    logic          prev_ack_a = 1'b0, prev_ack_b = 1'b0;
    exp_t          e;

    always @(negedge PCLK) begin
        if (!PRESETn) begin
            hold_rd_a = '0; hold_rd_b = '0; hold_err_a = 1'b0; hold_err_b = 1'b0;
        end else if (ack_a || ack_b) begin
            if (ack_a) chk("ack_a_one_cycle", 32'(prev_ack_a), 32'd0);
            if (ack_b) chk("ack_b_one_cycle", 32'(prev_ack_b), 32'd0);
            if (ack_a && ack_b) begin
                chk("ack_overlap", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack_b), 32'(exp_q.size()));
            end else begin
                e = exp_q.pop_front();
                chk("ack_side", 32'(ack_b), 32'(e.side));
                if (ack_a) begin
                    chk("rdata_a", 32'(rdata_a), 32'(e.rdata));
                    chk("err_a", 32'(err_a), 32'(e.err));
                    chk("hold_rdata_b", 32'(rdata_b), 32'(hold_rd_b));
                    chk("hold_err_b", 32'(err_b), 32'(hold_err_b));
                end else begin
                    chk("rdata_b", 32'(rdata_b), 32'(e.rdata));
                    chk("err_b", 32'(err_b), 32'(e.err));
                    chk("hold_rdata_a", 32'(rdata_a), 32'(hold_rd_a));
                    chk("hold_err_a", 32'(err_a), 32'(hold_err_a));
                end
                if (e.side) begin hold_rd_b = e.rdata; hold_err_b = e.err; end
                else        begin hold_rd_a = e.rdata; hold_err_a = e.err; end
            end
        end
        prev_ack_a = ack_a;
        prev_ack_b = ack_b;
    end

    task automatic expect_ack(input logic side, input logic [DW-1:0] rd, input logic er);
        exp_t x;
        x.side = side; x.rdata = rd; x.err = er;
        exp_q.push_back(x);
    endtask

    task automatic wait_ack(input logic side);
        int n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!(side ? ack_b : ack_a) && n < 200);
        chk(side ? "ack_b_arrived" : "ack_a_arrived", 32'(side ? ack_b : ack_a), 32'd1);
    endtask

    task automatic txn(input logic side, input logic wr, input logic [AW:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input logic exp_err);
        expect_ack(side, exp_rd, exp_err);
        @(negedge PCLK);
        if (side) begin wr_b = wr; addr_b = addr; wdata_b = wd; req_b = 1'b1; end
        else      begin wr_a = wr; addr_a = addr; wdata_a = wd; req_a = 1'b1; end
        wait_ack(side);
        if (side) req_b = 1'b0; else req_a = 1'b0;
    endtask

    initial begin
        int n, na, nb, c0;
        PRESETn = 1'b0;
        req_a = 0; wr_a = 0; addr_a = '0; wdata_a = '0;
        req_b = 0; wr_b = 0; addr_b = '0; wdata_b = '0;
        pready_en = 1'b1; slverr_en = 1'b0;
        repeat (3) @(negedge PCLK);

        // Reset values.
        chk("rst_outputs", {ack_a, ack_b, err_a, err_b, transfer, READ_WRITE},  32'd0);
        chk("rst_rdata", {rdata_a, rdata_b, apb_write_data}, 32'd0);
        chk("rst_paddr", {apb_write_paddr, apb_read_paddr}, 32'd0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // 1: single write from A, bridge inputs checked during GRANT.
        expect_ack(1'b0, 8'h00, 1'b0);
        wr_a = 1'b1; addr_a = 9'h005; wdata_a = 8'hA5; req_a = 1'b1;
        n = 0;
        do begin @(negedge PCLK); n++; end while (!transfer && n < 20);
        chk("t1_transfer", 32'(transfer), 32'd1);
        chk("t1_read_write", 32'(READ_WRITE), 32'd0);
        chk("t1_wpaddr", 32'(apb_write_paddr), 32'h005);
        chk("t1_rpaddr", 32'(apb_read_paddr), 32'h005);
        chk("t1_wdata", 32'(apb_write_data), 32'hA5);
        wait_ack(1'b0);
        req_a = 1'b0;
        @(negedge PCLK);
        chk("t1_mem1_5", 32'(mem1[5]), 32'hA5);
        chk("t1_transfer_low", 32'(transfer), 32'd0);

        // 2: A writes 0x3C to slave2, B reads it back.
        txn(1'b0, 1'b1, 9'h105, 8'h3C, 8'h00, 1'b0);
        txn(1'b1, 1'b0, 9'h105, 8'h00, 8'h3C, 1'b0);

        // 3: tie, both held for two reads each -> A,B,A,B.
        expect_ack(1'b0, 8'h45, 1'b0);
        expect_ack(1'b1, 8'hBA, 1'b0);
        expect_ack(1'b0, 8'h44, 1'b0);
        expect_ack(1'b1, 8'hBB, 1'b0);
        @(negedge PCLK);
        wr_a = 1'b0; addr_a = 9'h010; wr_b = 1'b0; addr_b = 9'h110;
        req_a = 1'b1; req_b = 1'b1;
        na = 0; nb = 0; n = 0;
        while ((na < 2 || nb < 2) && n < 400) begin
            @(negedge PCLK);
            n++;
            if (ack_a) begin na++; if (na == 2) req_a = 1'b0; else addr_a = 9'h011; end
            if (ack_b) begin nb++; if (nb == 2) req_b = 1'b0; else addr_b = 9'h111; end
        end
        chk("t3_all_acked", 32'(na * 16 + nb), 32'h22);

        // 4: watchdog abort with PREADY stuck low.
        pready_en = 1'b0;
        c0 = xfer_cnt;
        txn(1'b0, 1'b0, 9'h020, 8'h00, 8'h00, 1'b1);
        chk("t4_transfer_cycles", 32'(xfer_cnt - c0), 32'd17);
        pready_en = 1'b1;
        repeat (2) @(negedge PCLK);

        // 5: slave error on A, then a clean read on B.
        slverr_en = 1'b1;
        txn(1'b0, 1'b0, 9'h030, 8'h00, 8'h65, 1'b1);
        slverr_en = 1'b0;
        txn(1'b1, 1'b0, 9'h131, 8'h00, 8'h9B, 1'b0);

        // 6: reset during WAIT, no ack; then a tie from reset goes to A first.
        pready_en = 1'b0;
        @(negedge PCLK);
        wr_a = 1'b1; addr_a = 9'h050; wdata_a = 8'h77; req_a = 1'b1;
        n = 0;
        do begin @(negedge PCLK); n++; end while (!(PSEL_any && PENABLE) && n < 20);
        chk("t6_in_access", 32'(PSEL_any && PENABLE), 32'd1);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b0; req_a = 1'b0; pready_en = 1'b1;
        @(negedge PCLK);
        chk("t6_rst_transfer", 32'(transfer), 32'd0);
        chk("t6_rst_acks", {ack_a, ack_b, err_a, err_b}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("t6_idle_after_rst", 32'(transfer), 32'd0);
        expect_ack(1'b0, 8'h15, 1'b0);
        expect_ack(1'b1, 8'hEB, 1'b0);
        wr_a = 1'b0; addr_a = 9'h040; wr_b = 1'b0; addr_b = 9'h141;
        req_a = 1'b1; req_b = 1'b1;
        na = 0; nb = 0; n = 0;
        while ((na < 1 || nb < 1) && n < 200) begin
            @(negedge PCLK);
            n++;
            if (ack_a) begin na++; req_a = 1'b0; end
            if (ack_b) begin nb++; req_b = 1'b0; end
        end
        chk("t6_both_acked", 32'(na * 16 + nb), 32'h11);

        repeat (4) @(negedge PCLK);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
